// File: rtl/async_fifo_pkg.sv
// Shared constants and pointer-code helpers for both async FIFO controllers.
// Latency: none (constants and pure functions only).
// Backpressure: n/a.
//
// Holds the geometry (address width, pointer width, depth) and the Gray/binary
// conversions that must be identical on the write and read sides.
package async_fifo_pkg;

    localparam int ADDR_WIDTH = 7;
    localparam int PTR_WIDTH  = ADDR_WIDTH + 1;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    typedef logic [PTR_WIDTH-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin[PTR_WIDTH-1] = gray[PTR_WIDTH-1];
        for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Gray-code to binary converter for a synchronized FIFO pointer.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its input.
//
// Ports:
//   gray_i  Gray-coded pointer
//   bin_o   equivalent binary pointer
module gray2bin_conv #(
    parameter int PTR_WIDTH = 8
) (
    input  logic [PTR_WIDTH-1:0] gray_i,
    output logic [PTR_WIDTH-1:0] bin_o
);

    // Each binary bit is the XOR of all Gray bits at and above it; written as a
    // reduction per bit so there is no bit-to-bit combinational chain in one signal.
    for (genvar i = 0; i < PTR_WIDTH; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[PTR_WIDTH-1:i];
    end

endmodule

// File: rtl/async_fifo_write_ctrl.sv
// Write-domain controller of the async FIFO: RAM address, Gray write pointer, full/level/overflow status.
// Latency: write_enable same cycle; address/pointer/status registered, valid after the accepting edge.
// Backpressure: full blocks writes in the same cycle it is seen; rejected writes only set sticky overflow.
//
// Ports:
//   clock_write, write_reset_n   write-domain clock and async active-low reset
//   write_increment              client write request (one word per cycle)
//   sync_read_pointer            Gray read pointer already synchronized to clock_write
//   overflow_clear               synchronous clear of sticky overflow
//   write_pointer, write_address Gray pointer to the read side, binary RAM address
//   write_enable                 RAM write strobe (write_increment & !full)
//   full, almost_full            registered status flags
//   write_level                  registered occupancy estimate, 0..DEPTH
//   overflow                     sticky: write attempted while full
module async_fifo_write_ctrl #(
    parameter int ADDR_WIDTH        = 7,
    parameter int ALMOST_FULL_LEVEL = 120
) (
    input  logic                  clock_write,
    input  logic                  write_reset_n,
    input  logic                  write_increment,
    input  logic [ADDR_WIDTH:0]   sync_read_pointer,
    input  logic                  overflow_clear,
    output logic [ADDR_WIDTH:0]   write_pointer,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic                  write_enable,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   write_level,
    output logic                  overflow
);

    import async_fifo_pkg::*;

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam logic [PTR_W:0] AF_LEVEL = (PTR_W + 1)'(ALMOST_FULL_LEVEL);

    logic [PTR_W-1:0] wbin_q,  wbin_d;
    logic [PTR_W-1:0] wgray_q, wgray_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic             full_q,  full_d;
    logic             afull_q, afull_d;
    logic             ovf_q,   ovf_d;
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] full_match;

    gray2bin_conv #(
        .PTR_WIDTH (PTR_W)
    ) u_rptr_conv (
        .gray_i (sync_read_pointer),
        .bin_o  (rbin)
    );

    assign write_enable = write_increment & ~full_q;
    assign wbin_d       = wbin_q + PTR_W'(write_enable);

    // The shared helper is fixed to the package width; fall back to the
    // equivalent expression when this instance is built at another width.
    if (PTR_W == PTR_WIDTH) begin : g_gray_pkg
        assign wgray_d = bin2gray(wbin_d);
    end else begin : g_gray_local
        assign wgray_d = wbin_d ^ (wbin_d >> 1);
    end

    // In Gray code a pointer exactly one lap ahead differs from the read
    // pointer in its top two bits only.
    assign full_match = {~sync_read_pointer[PTR_W-1:PTR_W-2], sync_read_pointer[PTR_W-3:0]};
    assign full_d     = (wgray_d == full_match);

    // Modular difference; the extra pointer bit keeps DEPTH distinct from 0.
    assign level_d = wbin_d - rbin;
    assign afull_d = ({1'b0, level_d} >= AF_LEVEL);

    // Set takes priority over clear so a same-cycle overflow is never lost.
    assign ovf_d = (write_increment & full_q) | (ovf_q & ~overflow_clear);

    always_ff @(posedge clock_write or negedge write_reset_n) begin
        if (!write_reset_n) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            level_q <= level_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    assign write_pointer = wgray_q;
    assign write_address = wbin_q[ADDR_WIDTH-1:0];
    assign full          = full_q;
    assign almost_full   = afull_q;
    assign write_level   = level_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_async_fifo_write_ctrl.sv
// Self-checking bench for async_fifo_write_ctrl.
// Latency: expectations for each driven cycle are checked one edge later.
// Backpressure: bench model gates its write count on its own full flag.
module tb_async_fifo_write_ctrl;

    typedef struct {
        string      tag;
        logic [7:0] wp;
        logic [6:0] addr;
        logic       full;
        logic       afull;
        logic [7:0] level;
        logic       ovf;
    } exp_t;

    logic       clock_write = 1'b0;
    logic       write_reset_n = 1'b0;
    logic       write_increment = 1'b0;
    logic [7:0] sync_read_pointer = 8'h00;
    logic       overflow_clear = 1'b0;
    logic [7:0] write_pointer;
    logic [6:0] write_address;
    logic       write_enable;
    logic       full;
    logic       almost_full;
    logic [7:0] write_level;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: counts of accepted writes and of reads the writer has seen.
    int   m_wr = 0;
    int   m_rd = 0;
    logic m_full = 1'b0;
    logic m_ovf = 1'b0;

    exp_t sb[$];

    async_fifo_write_ctrl #(
        .ADDR_WIDTH        (7),
        .ALMOST_FULL_LEVEL (120)
    ) dut (
        .clock_write       (clock_write),
        .write_reset_n     (write_reset_n),
        .write_increment   (write_increment),
        .sync_read_pointer (sync_read_pointer),
        .overflow_clear    (overflow_clear),
        .write_pointer     (write_pointer),
        .write_address     (write_address),
        .write_enable      (write_enable),
        .full              (full),
        .almost_full       (almost_full),
        .write_level       (write_level),
        .overflow          (overflow)
    );

    always #5 clock_write = ~clock_write;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gray8(input int n);
        logic [7:0] b;
        b = n[7:0];
        return b ^ (b >> 1);
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, ".wp"},    write_pointer, 0);
        chk({tag, ".addr"},  write_address, 0);
        chk({tag, ".full"},  full, 0);
        chk({tag, ".afull"}, almost_full, 0);
        chk({tag, ".level"}, write_level, 0);
        chk({tag, ".ovf"},   overflow, 0);
    endtask

    // One clock: drive at negedge, check write_enable, push expectation,
    // pop and compare after the rising edge.
    task automatic step(input string tag, input logic inc, input logic clr, input logic rd_adv);
        exp_t e;
        exp_t o;
        int   lvl;
        logic accept;
        @(negedge clock_write);
        if (rd_adv) m_rd++;
        write_increment   = inc;
        overflow_clear    = clr;
        sync_read_pointer = gray8(m_rd);
        #1;
        accept = inc & ~m_full;
        chk({tag, ".we"}, write_enable, accept);
        m_ovf = (inc & m_full) | (m_ovf & ~clr);
        if (accept) m_wr++;
        lvl    = m_wr - m_rd;
        m_full = (lvl == 128);
        e.tag   = tag;
        e.wp    = gray8(m_wr);
        e.addr  = 7'(m_wr % 128);
        e.full  = m_full;
        e.afull = (lvl >= 120);
        e.level = 8'(lvl);
        e.ovf   = m_ovf;
        sb.push_back(e);
        @(posedge clock_write);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 1, 0);
        end else begin
            o = sb.pop_front();
            chk({o.tag, ".wp"},    write_pointer, o.wp);
            chk({o.tag, ".addr"},  write_address, o.addr);
            chk({o.tag, ".full"},  full,          o.full);
            chk({o.tag, ".afull"}, almost_full,   o.afull);
            chk({o.tag, ".level"}, write_level,   o.level);
            chk({o.tag, ".ovf"},   overflow,      o.ovf);
        end
    endtask

    initial begin
        // Reset held with a pending write request.
        write_reset_n   = 1'b0;
        write_increment = 1'b1;
        repeat (2) @(posedge clock_write);
        @(negedge clock_write);
        check_all_zero("reset");
        chk("reset.we", write_enable, 1);
        write_increment = 1'b0;
        write_reset_n   = 1'b1;
        #1;
        chk("first_addr", write_address, 0);

        // Fill to full from an empty FIFO; almost_full and full edges are
        // covered by the per-step comparisons at counts 119/120 and 127/128.
        for (int i = 0; i < 128; i++) step("fill", 1'b1, 1'b0, 1'b0);
        chk("fill.ptr_c0", write_pointer, 8'hC0);
        chk("fill.lvl128", write_level, 128);

        // Writes while full are rejected and set overflow.
        for (int i = 0; i < 3; i++) step("ovf_wr", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step("ovf_hold", 1'b0, 1'b0, 1'b0);
        step("ovf_clr_and_set", 1'b1, 1'b1, 1'b0);
        chk("ovf.set_wins", overflow, 1);
        step("ovf_clr", 1'b0, 1'b1, 1'b0);
        chk("ovf.cleared", overflow, 0);

        // One read becomes visible; one more write refills.
        step("drain", 1'b0, 1'b0, 1'b1);
        chk("drain.lvl127", write_level, 127);
        step("refill", 1'b1, 1'b0, 1'b0);
        chk("refill.ptr_c1", write_pointer, 8'hC1);
        chk("refill.full", full, 1);

        // Drain down to 4, then write and read in lockstep through pointer wrap.
        for (int i = 0; i < 124; i++) step("drain4", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) step("wrap", 1'b1, 1'b0, 1'b1);
        chk("wrap.level4", write_level, 4);

        // Asynchronous reset in the middle of a fill.
        @(negedge clock_write);
        write_reset_n     = 1'b0;
        sync_read_pointer = 8'h00;
        write_increment   = 1'b0;
        m_wr = 0; m_rd = 0; m_full = 1'b0; m_ovf = 1'b0;
        #1;
        check_all_zero("reset2");
        @(negedge clock_write);
        write_reset_n = 1'b1;
        for (int i = 0; i < 50; i++) step("fill50", 1'b1, 1'b0, 1'b0);
        @(negedge clock_write);
        write_increment = 1'b1;
        #2;
        write_reset_n = 1'b0;
        m_wr = 0; m_rd = 0; m_full = 1'b0; m_ovf = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clock_write);
        write_increment = 1'b0;
        write_reset_n   = 1'b1;
        #1;
        chk("midreset.addr0", write_address, 0);
        for (int i = 0; i < 5; i++) step("post_reset", 1'b1, 1'b0, 1'b0);

        chk("sb.drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
